// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pkg
// Description : Shared defaults and FSM state encoding for ram_16x8.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    localparam int RAM_DATA_W = 8;
    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DB_CYC = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STABLE  = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser for the raw write button plus the
//               stable-count counter steered by the ram_16x8 FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import ram_pkg::*;
#(
    parameter int DB_CYC = RAM_DB_CYC,
    parameter int CNT_W  = $clog2(DB_CYC + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             btn_raw_i,
    input  logic             cnt_clr_i,
    input  logic             cnt_inc_i,
    output logic             btn_sync_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             cnt_done_o
);

    logic             meta_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= btn_raw_i;
            sync_q <= meta_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (cnt_inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign btn_sync_o = sync_q;
    assign cnt_o      = cnt_q;
    assign cnt_done_o = (cnt_q == CNT_W'(DB_CYC - 1));

endmodule
`default_nettype wire

// File: rtl/ram_16x8.sv
`default_nettype none
// ============================================================================
// Module      : ram_16x8
// Description : Program/run-mode RAM with debounced pushbutton write.
//               Optional power-on clear sequence enabled by RAM_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_16x8
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DB_CYC = RAM_DB_CYC
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              prog,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] sw,
    input  logic              wr_btn,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ram_in,
    input  logic              ram_out,
    output logic [DATA_W-1:0] bus_out,
    output logic              busy,
    output logic              conflict
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(DB_CYC + 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    state_t            state_d;
    logic              conflict_q;
    logic              btn_s;
    logic              cnt_done;
    logic [CNT_W-1:0]  cnt_unused;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              fsm_we;
    logic              run_we;
    logic              in_clear;

    btn_debounce #(
        .DB_CYC (DB_CYC),
        .CNT_W  (CNT_W)
    ) u_btn_debounce (
        .clk        (clk),
        .clr        (clr),
        .btn_raw_i  (wr_btn),
        .cnt_clr_i  (cnt_clr),
        .cnt_inc_i  (cnt_inc),
        .btn_sync_o (btn_s),
        .cnt_o      (cnt_unused),
        .cnt_done_o (cnt_done)
    );

`ifdef RAM_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr_q;
    logic [ADDR_W-1:0] clr_addr_d;
    logic              clear_pend_q;
    logic              clr_we;

    // Set by reset, so it is high exactly on the first edge after clr falls.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clear_pend_q <= 1'b1;
            clr_addr_q   <= '0;
        end else begin
            clear_pend_q <= 1'b0;
            clr_addr_q   <= clr_addr_d;
        end
    end

    assign in_clear = (state_q == ST_CLEAR);
    assign clr_we   = in_clear;
`else
    assign in_clear = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        fsm_we  = 1'b0;
`ifdef RAM_CLEAR_EN
        clr_addr_d = clr_addr_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef RAM_CLEAR_EN
                if (clear_pend_q) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else
`endif
                if (btn_s && prog) begin
                    state_d = ST_STABLE;
                    cnt_clr = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!prog || !btn_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_done) begin
                    state_d = ST_WRITE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_WRITE: begin
                fsm_we  = 1'b1;
                cnt_clr = 1'b1;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Any bounce back high restarts the release count.
                if (!prog) begin
                    state_d = ST_IDLE;
                end else if (btn_s) begin
                    cnt_clr = 1'b1;
                end else if (cnt_done) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`ifdef RAM_CLEAR_EN
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            conflict_q <= ram_in && ram_out && !prog;
        end
    end

    assign run_we = !prog && ram_in && !in_clear;

    // Memory has no reset so clr never disturbs stored contents.
    always_ff @(posedge clk) begin
        if (fsm_we) begin
            mem[addr] <= sw;
`ifdef RAM_CLEAR_EN
        end else if (clr_we) begin
            mem[clr_addr_q] <= '0;
`endif
        end else if (run_we) begin
            mem[addr] <= bus_in;
        end
    end

    assign bus_out  = (ram_out && !ram_in && !prog) ? mem[addr] : '0;
    assign busy     = (state_q != ST_IDLE);
    assign conflict = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_16x8.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_16x8
// Description : Directed self-checking bench for ram_16x8 (default build and
//               RAM_CLEAR_EN build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_16x8;

    logic       clk = 1'b0;
    logic       clr;
    logic       prog;
    logic [3:0] addr;
    logic [7:0] sw;
    logic       wr_btn;
    logic [7:0] bus_in;
    logic       ram_in;
    logic       ram_out;
    logic [7:0] bus_out;
    logic       busy;
    logic       conflict;

    int checks = 0;
    int errors = 0;

    ram_16x8 #(.DATA_W(8), .ADDR_W(4), .DB_CYC(16)) dut (
        .clk      (clk),
        .clr      (clr),
        .prog     (prog),
        .addr     (addr),
        .sw       (sw),
        .wr_btn   (wr_btn),
        .bus_in   (bus_in),
        .ram_in   (ram_in),
        .ram_out  (ram_out),
        .bus_out  (bus_out),
        .busy     (busy),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_read(input logic [3:0] a);
        prog    = 1'b0;
        ram_in  = 1'b0;
        ram_out = 1'b1;
        addr    = a;
        #1;
    endtask

    task automatic wait_clear_done();
`ifdef RAM_CLEAR_EN
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (busy) n++;
            else if (n > 0) break;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL clear_busy_cycles: got %0d, expected 16", n);
        end
        for (int a = 0; a < 16; a++) begin
            set_read(4'(a));
            checks++;
            if (bus_out !== 8'h00) begin
                errors++;
                $display("FAIL clear_mem[%0d]: got %h, expected 00", a, bus_out);
            end
        end
        ram_out = 1'b0;
`else
        tick(3);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_clr: busy got %b, expected 0", busy);
        end
`endif
    endtask

    task automatic test_reset();
        clr = 1'b1; prog = 1'b0; addr = 4'h0; sw = 8'h00; wr_btn = 1'b0;
        bus_in = 8'h00; ram_in = 1'b0; ram_out = 1'b0;
        tick(3);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        checks++;
        if (conflict !== 1'b0) begin
            errors++; $display("FAIL reset_conflict: got %b, expected 0", conflict);
        end
        checks++;
        if (bus_out !== 8'h00) begin
            errors++; $display("FAIL reset_bus_out: got %h, expected 00", bus_out);
        end
        clr = 1'b0;
        wait_clear_done();
    endtask

    task automatic test_prog_write();
        prog = 1'b1; addr = 4'h3; sw = 8'hA5; wr_btn = 1'b1;
        tick(10);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL prog_busy_hold: got %b, expected 1", busy);
        end
        tick(20);
        sw = 8'h5A;  // a second write while still held would expose a double write
        tick(10);
        wr_btn = 1'b0;
        tick(25);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL prog_busy_release: got %b, expected 0", busy);
        end
        set_read(4'h3);
        checks++;
        if (bus_out !== 8'hA5) begin
            errors++; $display("FAIL prog_write_mem3: got %h, expected a5", bus_out);
        end
        ram_out = 1'b0;
    endtask

    task automatic test_glitch();
        prog = 1'b1; addr = 4'h3; sw = 8'hFF; wr_btn = 1'b1;
        tick(4);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL glitch_busy: got %b, expected 1", busy);
        end
        tick(1);
        wr_btn = 1'b0;
        tick(25);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL glitch_busy_return: got %b, expected 0", busy);
        end
        set_read(4'h3);
        checks++;
        if (bus_out !== 8'hA5) begin
            errors++; $display("FAIL glitch_mem3: got %h, expected a5", bus_out);
        end
        ram_out = 1'b0;
    endtask

    task automatic test_prog_drop();
        prog = 1'b1; addr = 4'h3; sw = 8'h66; wr_btn = 1'b1;
        tick(8);
        prog = 1'b0;
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL prog_drop_busy: got %b, expected 0", busy);
        end
        wr_btn = 1'b0;
        tick(30);
        set_read(4'h3);
        checks++;
        if (bus_out !== 8'hA5) begin
            errors++; $display("FAIL prog_drop_mem3: got %h, expected a5", bus_out);
        end
        ram_out = 1'b0;
    endtask

    task automatic test_run_write();
        prog = 1'b0; addr = 4'hF; bus_in = 8'h3C; ram_in = 1'b1; ram_out = 1'b0;
        tick(1);
        ram_in = 1'b0; ram_out = 1'b1;
        #1;
        checks++;
        if (bus_out !== 8'h3C) begin
            errors++; $display("FAIL run_write_mem15: got %h, expected 3c", bus_out);
        end
        checks++;
        if (conflict !== 1'b0) begin
            errors++; $display("FAIL run_no_conflict: got %b, expected 0", conflict);
        end
        prog = 1'b1;
        #1;
        checks++;
        if (bus_out !== 8'h00) begin
            errors++; $display("FAIL prog_blocks_out: got %h, expected 00", bus_out);
        end
        ram_out = 1'b0; ram_in = 1'b1; bus_in = 8'h77;
        tick(2);
        set_read(4'hF);
        checks++;
        if (bus_out !== 8'h3C) begin
            errors++; $display("FAIL prog_blocks_in: got %h, expected 3c", bus_out);
        end
        ram_out = 1'b0;
    endtask

    task automatic test_conflict();
        prog = 1'b0; addr = 4'h7; bus_in = 8'hC3; ram_in = 1'b1; ram_out = 1'b1;
        #1;
        checks++;
        if (bus_out !== 8'h00) begin
            errors++; $display("FAIL conflict_bus_out: got %h, expected 00", bus_out);
        end
        checks++;
        if (conflict !== 1'b0) begin
            errors++; $display("FAIL conflict_pre: got %b, expected 0", conflict);
        end
        tick(1);
        checks++;
        if (conflict !== 1'b1) begin
            errors++; $display("FAIL conflict_flag: got %b, expected 1", conflict);
        end
        ram_in = 1'b0;
        #1;
        checks++;
        if (bus_out !== 8'hC3) begin
            errors++; $display("FAIL conflict_mem7: got %h, expected c3", bus_out);
        end
        tick(1);
        checks++;
        if (conflict !== 1'b0) begin
            errors++; $display("FAIL conflict_clear: got %b, expected 0", conflict);
        end
        ram_out = 1'b0;
    endtask

    task automatic test_clr_mid_stable();
        prog = 1'b1; addr = 4'h3; sw = 8'h11; wr_btn = 1'b1;
        tick(8);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL clr_pre_busy: got %b, expected 1", busy);
        end
        clr = 1'b1;
        wr_btn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL clr_busy_immediate: got %b, expected 0", busy);
        end
        tick(2);
        clr = 1'b0;
`ifdef RAM_CLEAR_EN
        wait_clear_done();
`else
        tick(25);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL clr_busy_after: got %b, expected 0", busy);
        end
        set_read(4'h3);
        checks++;
        if (bus_out !== 8'hA5) begin
            errors++; $display("FAIL clr_mem3_kept: got %h, expected a5", bus_out);
        end
        ram_out = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_prog_write();
        test_glitch();
        test_prog_drop();
        test_run_write();
        test_conflict();
        test_clr_mid_stable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
